// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the writeback and register-file path.
//   N_REQ     number of writeback requesters sharing the register-file write port
//   AW, DW    register address width and register data width
//   REG_ZERO  address of the hard-wired zero register
//   req_idx_e requester index encoding of the writeback arbiter
package cpu_pkg;

  localparam int N_REQ = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_MDU  = 2'd2
  } req_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The scan starts at ptr and wraps modulo N.
// The first requester with valid set wins.
// The caller owns the pointer register and advances it after a grant.
// The arbiter is reusable for any shared port, for example the memory port.
//   valid      [N]   request vector
//   ptr        [IW]  requester with the highest priority in this cycle
//   grant      [N]   one-hot grant, all zero when nothing is requested
//   grant_idx  [IW]  encoded index of the granted requester
//   grant_vld  [1]   a grant was made
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  function automatic int wrap_idx(input int base, input int k);
    return (base + k) % N;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one
    // unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && valid[wrap_idx(int'(ptr), k)]) begin
        grant[wrap_idx(int'(ptr), k)] = 1'b1;
        grant_idx = IW'(wrap_idx(int'(ptr), k));
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a busy scoreboard.
// Several writeback requesters (ALU, LOAD, MDU) share the one register-file
// write port through round-robin arbitration.
// The accepted request becomes a registered write command one cycle later.
// A per-register busy scoreboard lets decode stall on read-after-write hazards.
//   clk, rst               clock; asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (ready is combinational)
//   req_addr/req_data      per-requester destination and data, slice i = requester i
//   req_cancel             consume the request but suppress the write
//   rsv_valid/rsv_addr     decode reserves a destination register
//   chk_addr1/2, chk_busy1/2  combinational hazard lookups
//   rf_we/rf_waddr/rf_wdata   registered write command to the register file
//   rsv_err                one-cycle pulse: a busy register was reserved again
module regfile_wb_arbiter #(
  parameter int N_REQ = cpu_pkg::N_REQ,
  parameter int AW    = cpu_pkg::AW,
  parameter int DW    = cpu_pkg::DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_cancel,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [AW-1:0]       chk_addr1,
  input  logic [AW-1:0]       chk_addr2,
  output logic                chk_busy1,
  output logic                chk_busy2,
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  output logic                rsv_err
);

  import cpu_pkg::*;

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREG = 1 << AW;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_nxt;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gidx;
  logic             gvld;

  logic [AW-1:0]    acc_addr;
  logic [DW-1:0]    acc_data;
  logic             acc_cancel;
  logic             acc_write;
  logic             rsv_set;
  logic             rsv_hit;

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (gvld)
  );

  // A grant is the handshake: the requester sees ready in the same cycle.
  assign req_ready = rst ? '0 : grant;

  assign acc_addr   = req_addr[int'(gidx)*AW +: AW];
  assign acc_data   = req_data[int'(gidx)*DW +: DW];
  assign acc_cancel = req_cancel[gidx];
  // A cancelled accept or an accept to $zero is consumed without a write.
  assign acc_write  = gvld && !acc_cancel && (acc_addr != REG_ZERO);

  assign ptr_nxt = (int'(gidx) == N_REQ - 1) ? '0 : gidx + IW'(1);

  assign rsv_set = rsv_valid && (rsv_addr != REG_ZERO);
  // The error is judged against the current busy bit. A clear that lands in
  // the same cycle does not mask it.
  assign rsv_hit = rsv_set && busy[rsv_addr];

  // Any accept to a nonzero register retires its reservation, cancelled ones
  // included. The set comes last so that a new reservation in the same cycle wins.
  always_comb begin
    busy_nxt = busy;
    if (gvld && (acc_addr != REG_ZERO)) busy_nxt[acc_addr] = 1'b0;
    if (rsv_set)                        busy_nxt[rsv_addr] = 1'b1;
  end

  assign chk_busy1 = (chk_addr1 != REG_ZERO) && busy[chk_addr1];
  assign chk_busy2 = (chk_addr2 != REG_ZERO) && busy[chk_addr2];

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rsv_err  <= 1'b0;
      // NOTE: busy is a flop vector, not a RAM, so it can be reset. Clearing
      // it here is how reset discards every outstanding reservation.
      busy     <= '0;
    end else begin
      rf_we   <= acc_write;
      rsv_err <= rsv_hit;
      busy    <= busy_nxt;
      if (gvld) ptr <= ptr_nxt;
      // The address and data load only on a real write. They hold through
      // every cycle in which rf_we is low.
      if (acc_write) begin
        rf_waddr <= acc_addr;
        rf_wdata <= acc_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_cancel;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rsv_err;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_cancel (req_cancel),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .chk_addr1  (chk_addr1),
    .chk_addr2  (chk_addr2),
    .chk_busy1  (chk_busy1),
    .chk_busy2  (chk_busy2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rsv_err    (rsv_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Each requester's data slice is tagged with its own index, so rf_wdata
  // shows which requester was served.
  function automatic logic [31:0] sd(input logic [31:0] d, input int i);
    return d ^ (32'(i) << 24);
  endfunction

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [31:0] data;
    logic [2:0]  cancel;
    logic        rsv_v;
    logic [4:0]  rsv_a;
    logic [4:0]  chk1;
    logic [4:0]  chk2;
    logic [2:0]  e_ready;
    logic        e_busy1;
    logic        e_busy2;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [14:0] addr, input logic [31:0] data,
    input logic [2:0] cancel, input logic rsv_v, input logic [4:0] rsv_a,
    input logic [4:0] chk1, input logic [4:0] chk2,
    input logic [2:0] e_ready, input logic e_busy1, input logic e_busy2,
    input logic e_we, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
    input logic e_err);
    vec_t v;
    v.valid = valid;  v.addr = addr;   v.data = data;   v.cancel = cancel;
    v.rsv_v = rsv_v;  v.rsv_a = rsv_a; v.chk1 = chk1;   v.chk2 = chk2;
    v.e_ready = e_ready; v.e_busy1 = e_busy1; v.e_busy2 = e_busy2;
    v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic [2:0] valid, input logic [14:0] addr,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [2:0] cancel, input logic rv, input logic [4:0] ra,
                       input logic [4:0] c1, input logic [4:0] c2);
    req_valid  = valid;
    req_addr   = addr;
    req_data   = {d2, d1, d0};
    req_cancel = cancel;
    rsv_valid  = rv;
    rsv_addr   = ra;
    chk_addr1  = c1;
    chk_addr2  = c2;
  endtask

  // Reference model state for the random phase.
  bit          m_busy[32];
  int          m_ptr;
  bit          m_we;
  bit          m_err;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          p_v[3];
  logic [4:0]  p_a[3];
  logic [31:0] p_d[3];
  bit          p_c[3];

  vec_t vecs[20];

  initial begin
    localparam logic [14:0] FA = {5'd3, 5'd2, 5'd1};
    rst = 1'b1;
    drive(3'b000, '0, '0, '0, '0, 3'b000, 1'b0, '0, '0, '0);

    // The fairness rows come first: the pointer is still at its reset value of 0.
    vecs[0]  = mk(3'b111, FA, 32'h100, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0,  32'h0, 0);
    vecs[1]  = mk(3'b111, FA, 32'h100, 0, 0, 0, 0, 0, 3'b010, 0, 0, 1, 1,  32'h0000_0100, 0);
    vecs[2]  = mk(3'b111, FA, 32'h100, 0, 0, 0, 0, 0, 3'b100, 0, 0, 1, 2,  32'h0100_0100, 0);
    vecs[3]  = mk(3'b111, FA, 32'h100, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 3,  32'h0200_0100, 0);
    vecs[4]  = mk(3'b111, FA, 32'h100, 0, 0, 0, 0, 0, 3'b010, 0, 0, 1, 1,  32'h0000_0100, 0);
    vecs[5]  = mk(3'b111, FA, 32'h100, 0, 0, 0, 0, 0, 3'b100, 0, 0, 1, 2,  32'h0100_0100, 0);
    // Single ALU write.
    vecs[6]  = mk(3'b001, {10'd0, 5'd8}, 32'h1234_5678, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 3, 32'h0200_0100, 0);
    vecs[7]  = mk(3'b000, '0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 8,  32'h1234_5678, 0);
    // Reservations, then a cancelled write and a write to $zero.
    vecs[8]  = mk(3'b000, '0, 0, 0, 1, 9,  9,  0, 3'b000, 0, 0, 0, 8,  32'h1234_5678, 0);
    vecs[9]  = mk(3'b000, '0, 0, 0, 1, 12, 9,  0, 3'b000, 1, 0, 0, 8,  32'h1234_5678, 0);
    vecs[10] = mk(3'b001, {10'd0, 5'd9}, 32'hDEAD, 3'b001, 0, 0, 12, 0, 3'b001, 1, 0, 0, 8, 32'h1234_5678, 0);
    vecs[11] = mk(3'b010, 15'd0, 32'hFFFF_FFFF, 0, 0, 0, 9, 0, 3'b010, 0, 0, 0, 8, 32'h1234_5678, 0);
    // MDU write to 12 while 12 is reserved again: the set wins.
    vecs[12] = mk(3'b100, {5'd12, 10'd0}, 32'hCAFE_F00D, 0, 1, 12, 12, 0, 3'b100, 1, 0, 0, 8, 32'h1234_5678, 0);
    vecs[13] = mk(3'b000, '0, 0, 0, 0, 0, 12, 0, 3'b000, 1, 0, 1, 12, 32'hC8FE_F00D, 1);
    vecs[14] = mk(3'b100, {5'd12, 10'd0}, 32'h55, 0, 0, 0, 12, 0, 3'b100, 1, 0, 0, 12, 32'hC8FE_F00D, 0);
    vecs[15] = mk(3'b000, '0, 0, 0, 0, 0, 12, 0, 3'b000, 0, 0, 1, 12, 32'h0200_0055, 0);
    // Double reservation of register 3.
    vecs[16] = mk(3'b000, '0, 0, 0, 1, 3, 3, 0, 3'b000, 0, 0, 0, 12, 32'h0200_0055, 0);
    vecs[17] = mk(3'b000, '0, 0, 0, 1, 3, 3, 0, 3'b000, 1, 0, 0, 12, 32'h0200_0055, 0);
    vecs[18] = mk(3'b000, '0, 0, 0, 0, 0, 3, 0, 3'b000, 1, 0, 0, 12, 32'h0200_0055, 1);
    vecs[19] = mk(3'b000, '0, 0, 0, 0, 0, 3, 3, 3'b000, 1, 1, 0, 12, 32'h0200_0055, 0);

    // Reset values, and ready stays low while rst is high.
    #2;
    check("reset rf_we", 64'(rf_we), 64'd0);
    check("reset rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset rsv_err", 64'(rsv_err), 64'd0);
    req_valid = 3'b111;
    #1;
    check("reset req_ready", 64'(req_ready), 64'd0);
    req_valid = 3'b000;
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].valid, vecs[i].addr, sd(vecs[i].data, 0), sd(vecs[i].data, 1),
            sd(vecs[i].data, 2), vecs[i].cancel, vecs[i].rsv_v, vecs[i].rsv_a,
            vecs[i].chk1, vecs[i].chk2);
      @(negedge clk);
      check($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
      check($sformatf("vec%0d chk_busy1", i), 64'(chk_busy1), 64'(vecs[i].e_busy1));
      check($sformatf("vec%0d chk_busy2", i), 64'(chk_busy2), 64'(vecs[i].e_busy2));
      check($sformatf("vec%0d rf_we", i), 64'(rf_we), 64'(vecs[i].e_we));
      check($sformatf("vec%0d rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].e_waddr));
      check($sformatf("vec%0d rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].e_wdata));
      check($sformatf("vec%0d rsv_err", i), 64'(rsv_err), 64'(vecs[i].e_err));
      @(posedge clk);
      #1;
    end

    // Reset in mid-run: busy[5] is set, the pointer has moved off 0 and a write
    // command is showing.
    drive(3'b001, {10'd0, 5'd7}, 32'h77, 0, 0, 3'b000, 1'b1, 5'd5, 5'd5, 5'd0);
    @(posedge clk);
    #1;
    drive(3'b000, '0, 0, 0, 0, 3'b000, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    check("prerst chk_busy1", 64'(chk_busy1), 64'd1);
    check("prerst rf_we", 64'(rf_we), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst rf_we", 64'(rf_we), 64'd0);
    check("midrst rf_waddr", 64'(rf_waddr), 64'd0);
    check("midrst rf_wdata", 64'(rf_wdata), 64'd0);
    check("midrst rsv_err", 64'(rsv_err), 64'd0);
    check("midrst chk_busy1", 64'(chk_busy1), 64'd0);
    req_valid = 3'b111;
    #1;
    check("midrst req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    req_valid = 3'b101;
    #1;
    check("postrst ptr0 grant", 64'(req_ready), 64'b001);
    req_valid = 3'b000;
    @(posedge clk);
    #1;

    // Random phase against the reference model, starting from reset state.
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr = 0; m_we = 0; m_err = 0; m_waddr = '0; m_wdata = '0;
    foreach (p_v[i]) p_v[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      bit rv;
      logic [4:0] ra, c1, c2;
      logic [2:0] exp_ready;
      bit new_err;
      for (int i = 0; i < 3; i++) begin
        if (!p_v[i] && ($urandom_range(1, 0) == 1)) begin
          p_v[i] = 1'b1;
          p_a[i] = 5'($urandom_range(7, 0));
          p_d[i] = $urandom;
          p_c[i] = ($urandom_range(3, 0) == 0);
        end
      end
      rv = ($urandom_range(2, 0) == 0);
      ra = 5'($urandom_range(7, 0));
      c1 = 5'($urandom_range(7, 0));
      c2 = 5'($urandom_range(7, 0));
      drive({p_v[2], p_v[1], p_v[0]}, {p_a[2], p_a[1], p_a[0]}, p_d[0], p_d[1], p_d[2],
            {p_c[2], p_c[1], p_c[0]}, rv, ra, c1, c2);

      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && p_v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;

      @(negedge clk);
      check($sformatf("rnd%0d req_ready", cyc), 64'(req_ready), 64'(exp_ready));
      check($sformatf("rnd%0d chk_busy1", cyc), 64'(chk_busy1), 64'(c1 != 0 && m_busy[c1]));
      check($sformatf("rnd%0d chk_busy2", cyc), 64'(chk_busy2), 64'(c2 != 0 && m_busy[c2]));
      check($sformatf("rnd%0d rf_we", cyc), 64'(rf_we), 64'(m_we));
      check($sformatf("rnd%0d rf_waddr", cyc), 64'(rf_waddr), 64'(m_waddr));
      check($sformatf("rnd%0d rf_wdata", cyc), 64'(rf_wdata), 64'(m_wdata));
      check($sformatf("rnd%0d rsv_err", cyc), 64'(rsv_err), 64'(m_err));
      @(posedge clk);

      new_err = rv && (ra != 0) && m_busy[ra];
      if (g >= 0) begin
        m_ptr = (g + 1) % 3;
        m_we  = !p_c[g] && (p_a[g] != 0);
        if (m_we) begin
          m_waddr = p_a[g];
          m_wdata = p_d[g];
        end
        if (p_a[g] != 0) m_busy[p_a[g]] = 1'b0;
        p_v[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (rv && ra != 0) m_busy[ra] = 1'b1;
      m_err = new_err;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between N writeback requesters (ALU, load unit, mul/div unit) using round-robin arbitration with a valid/ready handshake.
- Drives a registered write command (rf_we/rf_waddr/rf_wdata) to the register file. The register file commits it on the falling edge inside the cycle the command is presented.
- Keeps a per-register busy scoreboard so decode can stall on read-after-write hazards against outstanding multi-cycle results.

Parameters:
- N_REQ, 3, number of writeback requesters; index 0 = ALU, 1 = LOAD, 2 = MDU.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester write request.
- req_ready  out  N_REQ  per-requester grant; combinational, at most one bit set.
- req_addr  in  N_REQ*AW  destination register; slice i belongs to requester i.
- req_data  in  N_REQ*DW  write data; slice i belongs to requester i.
- req_cancel  in  N_REQ  suppress the write (e.g. add/sub overflow); the request is still consumed.
- rsv_valid  in  1  decode issues an instruction that will write rsv_addr later.
- rsv_addr  in  AW  register to reserve.
- chk_addr1  in  AW  source register 1 to hazard-check.
- chk_addr2  in  AW  source register 2 to hazard-check.
- chk_busy1  out  1  combinational; chk_addr1 has an outstanding write.
- chk_busy2  out  1  combinational; chk_addr2 has an outstanding write.
- rf_we  out  1  registered write enable to the register file.
- rf_waddr  out  AW  registered write address.
- rf_wdata  out  DW  registered write data.
- rsv_err  out  1  registered one-cycle pulse on reservation of an already busy register.

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_waddr=0, rf_wdata=0, rsv_err=0.
  - busy[31:0]=0, round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards all reservations and any command not yet presented.
- Arbitration:
  - Scan requesters starting at ptr, wrapping modulo N_REQ; the first with req_valid=1 is granted (req_ready[g]=1).
  - Handshake completes in the same cycle as valid&&ready.
  - On a grant, ptr <= (g+1) mod N_REQ at the next posedge. With no request, ptr holds.
  - Requesters must hold valid, addr, data and cancel stable until ready is seen.
- Write command, 1-cycle latency:
  - In the cycle after an accept, rf_we=1, rf_waddr=addr, rf_wdata=data.
  - rf_we=0 instead if the accepted request had cancel=1 or addr=0.
  - rf_we=0 in any cycle following no accept. rf_waddr/rf_wdata hold their last values when rf_we=0.
- Scoreboard:
  - rsv_valid with rsv_addr!=0 sets busy[rsv_addr] at the next posedge.
  - An accept with addr!=0 clears busy[addr] at the next posedge, including cancelled accepts.
  - Set and clear of the same address in the same cycle: set wins.
  - Reservation of a register whose busy bit is already 1: bit stays 1 and rsv_err pulses for one cycle. One outstanding write per register is a decode-side rule.
  - Register 0 is never busy. chk_busyN = (chk_addrN!=0) && busy[chk_addrN].
  - A clear in cycle t is visible on chk_busy in cycle t+1. The data is committed at the falling edge of t+1, so a consumer sampling at the end of t+1 sees the new value.
- Accepts to non-reserved registers (single-cycle ALU results) are legal and leave the scoreboard unchanged.

Decomposition:
- Shared package (cpu_pkg):
  - Constants REG_ZERO=0, AW, DW, N_REQ.
  - Requester index enum: REQ_ALU, REQ_LOAD, REQ_MDU.
- One natural sub-module: rr_arbiter, parameterised by N, taking valid and ptr and returning a one-hot grant plus an encoded index. It is reusable for the memory port.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset then idle: rst pulse mid-run with busy[5]=1 -> all outputs 0, chk_busy1=0 for chk_addr1=5, ptr=0.
- Single ALU write: req_valid=001, addr=8, data=0x1234_5678 -> req_ready=001 same cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=0x12345678.
- Fairness: req_valid=111 held for 6 cycles, each requester re-presenting after its grant -> grant order 0,1,2,0,1,2; rf_we=1 on all 6 following cycles.
- Cancel and $zero: ALU addr=9 cancel=1, then LOAD addr=0 data=0xFFFF_FFFF -> both consumed, rf_we=0 for both; busy[9] cleared if previously reserved.
- Scoreboard: rsv addr=12, then check 12 -> chk_busy1=1. After the MDU accept to addr=12 -> chk_busy1=0 next cycle. Reserve 12 again in the same cycle as the MDU accept -> busy stays 1.
- Double reservation: rsv addr=3 twice without a write -> rsv_err=1 for exactly one cycle after the second; busy[3]=1.
